// File: rtl/change_dispenser_pkg.sv
// -----------------------------------------------------------------------------
// change_dispenser_pkg
// Shared definitions for the change dispenser and the vending FSM:
//   - coin-code constants (same encoding as the vending coin input)
//   - coin value table in Rs.5 units, indexed by coin code
//   - dispenser FSM state encoding
// -----------------------------------------------------------------------------
package change_dispenser_pkg;

    localparam logic [1:0] COIN_5  = 2'b00;
    localparam logic [1:0] COIN_10 = 2'b01;
    localparam logic [1:0] COIN_15 = 2'b10;
    localparam logic [1:0] COIN_20 = 2'b11;

    // Value of each coin in Rs.5 units, indexed by its code.
    localparam logic [2:0] COIN_VALUE [4] = '{3'd1, 3'd2, 3'd3, 3'd4};

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StPay  = 2'b01,
        StDone = 2'b10,
        StErr  = 2'b11
    } chg_state_e;

endpackage

// File: rtl/coin_select.sv
// -----------------------------------------------------------------------------
// coin_select
// Combinational greedy coin chooser: largest coin not exceeding the remaining
// amount (capped at Rs.20).
// Ports:
//   i_remaining  [AMT_W-1:0]  amount still to pay, Rs.5 units
//   o_coin_code  [1:0]        code of the coin to offer
//   o_coin_value [2:0]        value of that coin in Rs.5 units (1..4)
// For i_remaining == 0 the outputs are COIN_5 / 1; callers never pay then.
// -----------------------------------------------------------------------------
module coin_select
    import change_dispenser_pkg::*;
#(
    parameter int unsigned AMT_W = 5
) (
    input  logic [AMT_W-1:0] i_remaining,
    output logic [1:0]       o_coin_code,
    output logic [2:0]       o_coin_value
);

    always_comb begin
        o_coin_code = COIN_5;
        if (i_remaining >= AMT_W'(4)) begin
            o_coin_code = COIN_20;
        end else begin
            unique case (i_remaining[1:0])
                2'd3:    o_coin_code = COIN_15;
                2'd2:    o_coin_code = COIN_10;
                default: o_coin_code = COIN_5;
            endcase
        end
        o_coin_value = COIN_VALUE[o_coin_code];
    end

endmodule

// File: rtl/change_dispenser.sv
// -----------------------------------------------------------------------------
// change_dispenser
// Pays out a refund as a stream of coins to a hopper, greedy largest-first,
// using a valid/ready handshake. All outputs are registered.
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset (priority over everything)
//   refund_req  one-cycle request, accepted only in IDLE
//   refund_amt  refund amount in Rs.5 units
//   coin_valid  a coin is offered to the hopper
//   coin_code   offered coin (00=Rs.5 .. 11=Rs.20), 00 when not valid
//   coin_ready  hopper accepts the offered coin this cycle
//   busy        payout in progress (PAY and DONE)
//   done        one-cycle completion pulse
//   err         hopper stall error, sticky until rst
// Configuration:
//   CHG_TIMEOUT_EN  when defined, TIMEOUT consecutive stalled PAY cycles move
//                   the FSM to ERR; otherwise err is tied low and PAY waits
//                   indefinitely for coin_ready.
// -----------------------------------------------------------------------------
module change_dispenser
    import change_dispenser_pkg::*;
#(
    parameter int unsigned AMT_W   = 5,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             refund_req,
    input  logic [AMT_W-1:0] refund_amt,
    output logic             coin_valid,
    output logic [1:0]       coin_code,
    input  logic             coin_ready,
    output logic             busy,
    output logic             done,
    output logic             err
);

    chg_state_e       r_state;
    logic [AMT_W-1:0] r_remaining;
    logic             r_coin_valid;
    logic [1:0]       r_coin_code;
    logic             r_busy;
    logic             r_done;

    logic [2:0]       w_cur_value;
    logic [1:0]       w_cur_code_unused;
    logic [AMT_W-1:0] w_rem_after;
    logic [AMT_W-1:0] w_next_sel;
    logic [1:0]       w_next_code;
    logic [2:0]       w_next_value_unused;

    // Value of the coin currently offered; drives the decrement on transfer.
    coin_select #(
        .AMT_W (AMT_W)
    ) u_sel_cur (
        .i_remaining  (r_remaining),
        .o_coin_code  (w_cur_code_unused),
        .o_coin_value (w_cur_value)
    );

    // Greedy value never exceeds remaining, so this cannot underflow in PAY.
    assign w_rem_after = r_remaining - AMT_W'(w_cur_value);

    // Outputs are registered, so the code for the next cycle is chosen from
    // the amount that will be remaining after this edge.
    assign w_next_sel = (r_state == StPay) ? w_rem_after : refund_amt;

    coin_select #(
        .AMT_W (AMT_W)
    ) u_sel_next (
        .i_remaining  (w_next_sel),
        .o_coin_code  (w_next_code),
        .o_coin_value (w_next_value_unused)
    );

`ifdef CHG_TIMEOUT_EN
    localparam int unsigned STALL_W = $clog2(TIMEOUT + 1);
    logic [STALL_W-1:0] r_stall;
    logic               r_err;
`else
    localparam int unsigned unused_timeout = TIMEOUT;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= StIdle;
            r_remaining  <= '0;
            r_coin_valid <= 1'b0;
            r_coin_code  <= COIN_5;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
`ifdef CHG_TIMEOUT_EN
            r_stall      <= '0;
            r_err        <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (refund_req) begin
                        r_remaining <= refund_amt;
                        r_busy      <= 1'b1;
                        if (refund_amt == '0) begin
                            r_state <= StDone;
                            r_done  <= 1'b1;
                        end else begin
                            r_state      <= StPay;
                            r_coin_valid <= 1'b1;
                            r_coin_code  <= w_next_code;
                        end
                    end
                end
                StPay: begin
                    if (coin_ready) begin
                        r_remaining <= w_rem_after;
`ifdef CHG_TIMEOUT_EN
                        r_stall     <= '0;
`endif
                        if (w_rem_after == '0) begin
                            r_state      <= StDone;
                            r_coin_valid <= 1'b0;
                            r_coin_code  <= COIN_5;
                            r_done       <= 1'b1;
                        end else begin
                            r_coin_code <= w_next_code;
                        end
                    end
`ifdef CHG_TIMEOUT_EN
                    else if (r_stall == STALL_W'(TIMEOUT - 1)) begin
                        r_state      <= StErr;
                        r_coin_valid <= 1'b0;
                        r_coin_code  <= COIN_5;
                        r_busy       <= 1'b0;
                        r_err        <= 1'b1;
                    end else begin
                        r_stall <= r_stall + 1'b1;
                    end
`endif
                end
                StDone: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                StErr: begin
                    // Sticky until reset.
                    r_state <= StErr;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign coin_valid = r_coin_valid;
    assign coin_code  = r_coin_code;
    assign busy       = r_busy;
    assign done       = r_done;
`ifdef CHG_TIMEOUT_EN
    assign err        = r_err;
`else
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// -----------------------------------------------------------------------------
// tb_change_dispenser
// Self-checking bench for change_dispenser. Expected coin sequences come from
// a greedy model (coin = min(remaining, 4) units) built as a queue per refund.
// -----------------------------------------------------------------------------
module tb_change_dispenser;

    localparam int unsigned AMT_W   = 5;
    localparam int unsigned TIMEOUT = 16;

    logic             clk;
    logic             rst;
    logic             refund_req;
    logic [AMT_W-1:0] refund_amt;
    logic             coin_valid;
    logic [1:0]       coin_code;
    logic             coin_ready;
    logic             busy;
    logic             done;
    logic             err;

    int checks;
    int failures;

    // {coin_valid, coin_code, busy, done, err}
    logic [5:0] obs;
    assign obs = {1'b0, coin_valid, coin_code, busy, done, err};

    change_dispenser #(
        .AMT_W   (AMT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .refund_req (refund_req),
        .refund_amt (refund_amt),
        .coin_valid (coin_valid),
        .coin_code  (coin_code),
        .coin_ready (coin_ready),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] pack(input logic v, input logic [1:0] c, input logic b,
                                        input logic d, input logic e);
        return {1'b0, v, c, b, d, e};
    endfunction

    task automatic test_reset();
        rst        = 1'b1;
        refund_req = 1'b1;
        refund_amt = AMT_W'(5);
        coin_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (obs !== 6'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected %b", obs, 6'd0);
        end
        rst        = 1'b0;
        refund_req = 1'b0;
        coin_ready = 1'b0;
        tick();
        checks++;
        if (obs !== 6'd0) begin
            failures++;
            $display("FAIL reset_idle: got %b expected %b", obs, 6'd0);
        end
    endtask

    // mode 0: ready always 1; mode 1: random ready with spurious requests;
    // mode 2: first coin stalled 3 cycles, with spurious requests.
    task automatic run_payout(input int amt, input int mode, input string name);
        int         q[$];
        int         r;
        int         c;
        int         idx;
        int         cyc;
        int         stall_run;
        logic       rdy;
        logic [5:0] exp;
        r = amt;
        while (r > 0) begin
            c = (r >= 4) ? 4 : r;
            q.push_back(c - 1);
            r -= c;
        end
        refund_amt = AMT_W'(amt);
        refund_req = 1'b1;
        tick();
        refund_req = 1'b0;
        idx = 0;
        cyc = 0;
        stall_run = 0;
        while (idx < q.size() && cyc < 200) begin
            exp = pack(1'b1, 2'(q[idx]), 1'b1, 1'b0, 1'b0);
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL %s coin%0d cyc%0d: got %b expected %b", name, idx, cyc, obs, exp);
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (stall_run >= 3) ? 1'b1 : ($urandom_range(0, 2) != 0);
                default: rdy = (idx != 0) || (cyc >= 3);
            endcase
            if (mode != 0 && $urandom_range(0, 2) == 0) begin
                refund_req = 1'b1;
                refund_amt = AMT_W'($urandom);
            end
            coin_ready = rdy;
            tick();
            refund_req = 1'b0;
            coin_ready = 1'b0;
            if (rdy) begin
                idx++;
                stall_run = 0;
            end else begin
                stall_run++;
            end
            cyc++;
        end
        if (idx < q.size()) begin
            checks++;
            failures++;
            $display("FAIL %s payout_bound: got %0d coins expected %0d", name, idx, q.size());
        end
        exp = pack(1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s done_cycle: got %b expected %b", name, obs, exp);
        end
        tick();
        checks++;
        if (obs !== 6'd0) begin
            failures++;
            $display("FAIL %s back_idle: got %b expected %b", name, obs, 6'd0);
        end
    endtask

    task automatic test_directed();
        run_payout(9, 0, "amt9");
        run_payout(7, 0, "amt7");
        run_payout(1, 0, "amt1");
        run_payout(0, 0, "amt0");
        run_payout(6, 2, "amt6_stall");
        run_payout(31, 0, "amt31");
    endtask

    task automatic test_random();
        int amt;
        for (int i = 0; i < 25; i++) begin
            amt = $urandom_range(0, 31);
            run_payout(amt, $urandom_range(0, 1), $sformatf("rand%0d_amt%0d", i, amt));
        end
    endtask

    task automatic test_back_to_back();
        // New request accepted in the IDLE cycle right after DONE.
        for (int i = 0; i < 4; i++) begin
            run_payout(4 + i, 0, $sformatf("b2b%0d", i));
        end
    endtask

    task automatic test_reset_mid();
        logic [5:0] exp;
        refund_amt = AMT_W'(12);
        refund_req = 1'b1;
        tick();
        refund_req = 1'b0;
        coin_ready = 1'b1;
        tick();
        exp = pack(1'b1, 2'b11, 1'b1, 1'b0, 1'b0);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL rst_mid_second_coin: got %b expected %b", obs, exp);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (obs !== 6'd0) begin
            failures++;
            $display("FAIL rst_mid_outputs: got %b expected %b", obs, 6'd0);
        end
        tick();
        checks++;
        if (obs !== 6'd0) begin
            failures++;
            $display("FAIL rst_mid_not_resumed: got %b expected %b", obs, 6'd0);
        end
        coin_ready = 1'b0;
        run_payout(2, 0, "after_rst_amt2");
    endtask

    task automatic test_timeout();
        logic [5:0] exp;
        refund_amt = AMT_W'(10);
        refund_req = 1'b1;
        coin_ready = 1'b0;
        tick();
        refund_req = 1'b0;
`ifdef CHG_TIMEOUT_EN
        for (int k = 1; k <= int'(TIMEOUT); k++) begin
            tick();
            if (k < int'(TIMEOUT)) exp = pack(1'b1, 2'b11, 1'b1, 1'b0, 1'b0);
            else                   exp = pack(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL timeout_stall%0d: got %b expected %b", k, obs, exp);
            end
        end
        refund_req = 1'b1;
        coin_ready = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        refund_req = 1'b0;
        coin_ready = 1'b0;
        exp = pack(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL timeout_sticky: got %b expected %b", obs, exp);
        end
`else
        for (int k = 0; k < 100; k++) tick();
        exp = pack(1'b1, 2'b11, 1'b1, 1'b0, 1'b0);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL no_timeout_wait: got %b expected %b", obs, exp);
        end
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (obs !== 6'd0) begin
            failures++;
            $display("FAIL timeout_rst_clear: got %b expected %b", obs, 6'd0);
        end
        tick();
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        refund_req = 1'b0;
        refund_amt = '0;
        coin_ready = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
